// File: rtl/spi_word_reader_if.sv
// spi_word_reader_if: start/status handshake, SPI pins and word output for spi_word_reader.
interface spi_word_reader_if #(parameter int WORD_BITS = 12);
    logic                 start;
    logic                 busy;
    logic                 SPI_clk;
    logic                 cs;
    logic                 MISO;
    logic [WORD_BITS-1:0] data_out;
    logic                 data_valid;
    modport master (input start, MISO, output busy, SPI_clk, cs, data_out, data_valid);
    modport slave  (output start, MISO, input busy, SPI_clk, cs, data_out, data_valid);
endinterface

// File: rtl/spi_word_reader.sv
// spi_word_reader: SPI mode-0 master reading one WORD_BITS word per start.
// Define SPI_READER_AUTO_EN to re-arm automatically after each GAP and ignore start.
module spi_word_reader #(
    parameter int CLK_DIV   = 4,
    parameter int WORD_BITS = 12
) (
    input logic                clk,
    input logic                rst,
    spi_word_reader_if.master  bus
);
    localparam int TW = $clog2(2*WORD_BITS+1);
    typedef enum logic [1:0] {IDLE, SETUP, SHIFT, GAP} state_t;
    state_t               state_q;
    logic [7:0]           div_q;
    logic [TW-1:0]        tog_q;
    logic [WORD_BITS-1:0] sh_q, data_q;
    logic                 sclk_q, cs_q, busy_q, dv_q;
    logic                 div_end, go;
    assign div_end = div_q == 8'(CLK_DIV-1);
`ifdef SPI_READER_AUTO_EN
    assign go = 1'b1;
`else
    assign go = bus.start;
`endif
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            div_q   <= '0;
            tog_q   <= '0;
            sh_q    <= '0;
            data_q  <= '0;
            sclk_q  <= 1'b0;
            cs_q    <= 1'b1;
            busy_q  <= 1'b0;
            dv_q    <= 1'b0;
        end else begin
            dv_q  <= 1'b0;
            div_q <= div_end ? '0 : div_q + 8'd1;
            case (state_q)
                IDLE: begin
                    div_q <= '0;
                    if (go) begin
                        state_q <= SETUP;
                        cs_q    <= 1'b0;
                        busy_q  <= 1'b1;
                    end
                end
                SETUP: if (div_end) state_q <= SHIFT;
                SHIFT: if (div_end) begin
                    sclk_q <= ~sclk_q;
                    tog_q  <= tog_q + 1'b1;
                    if (!sclk_q) sh_q <= {sh_q[WORD_BITS-2:0], bus.MISO};
                    // final falling edge closes the frame
                    if (tog_q == TW'(2*WORD_BITS-1)) begin
                        state_q <= GAP;
                        tog_q   <= '0;
                        cs_q    <= 1'b1;
                        data_q  <= sh_q;
                        dv_q    <= 1'b1;
                    end
                end
                GAP: if (div_end) begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
                default: state_q <= IDLE;
            endcase
        end
    end
    assign bus.SPI_clk    = sclk_q;
    assign bus.cs         = cs_q;
    assign bus.busy       = busy_q;
    assign bus.data_out   = data_q;
    assign bus.data_valid = dv_q;
endmodule

// File: tb/tb_spi_word_reader.sv
// tb_spi_word_reader: directed table-driven bench for spi_word_reader (CLK_DIV=4 and CLK_DIV=1 instances).
module tb_spi_word_reader;
    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   errors = 0;
    logic [11:0] word0, word1;
    int   idx0, idx1;

    always #5 clk = ~clk;

    spi_word_reader_if #(.WORD_BITS(12)) bus0();
    spi_word_reader_if #(.WORD_BITS(12)) bus1();
    spi_word_reader #(.CLK_DIV(4), .WORD_BITS(12)) u0 (.clk(clk), .rst(rst), .bus(bus0));
    spi_word_reader #(.CLK_DIV(1), .WORD_BITS(12)) u1 (.clk(clk), .rst(rst), .bus(bus1));

    // slave models: first bit presented at cs fall, next bits on each SPI_clk fall
    always @(negedge bus0.cs) begin idx0 = 11; bus0.MISO = word0[11]; end
    always @(negedge bus0.SPI_clk) if (!bus0.cs && idx0 > 0) begin idx0--; bus0.MISO = word0[idx0]; end
    always @(negedge bus1.cs) begin idx1 = 11; bus1.MISO = word1[11]; end
    always @(negedge bus1.SPI_clk) if (!bus1.cs && idx1 > 0) begin idx1--; bus1.MISO = word1[idx1]; end

    typedef struct {
        logic [11:0] word;
        logic [11:0] exp;
        int          lat;
    } vec_t;
    vec_t vecs[4];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic read0(input logic [11:0] w, input logic [11:0] exp, input int lat_exp, input bit repulse);
        int lat = 0, cs_low = 0, rises = 0, run = 0, bad_width = 0, bad_hold = 0, extra_dv = 0, busy_n = 0;
        logic prev = 1'b0;
        logic [11:0] old = bus0.data_out;
        word0 = w;
        @(negedge clk); bus0.start = 1'b1;
        @(negedge clk); bus0.start = 1'b0;
        for (int n = 1; n <= 400; n++) begin
            if (n > 1) @(negedge clk);
            if (repulse && n == 50) bus0.start = 1'b1;
            if (repulse && n == 51) bus0.start = 1'b0;
            if (!bus0.cs) cs_low++;
            if (bus0.SPI_clk !== prev) begin
                if (prev && run != 4) bad_width++;
                if (!prev && rises > 0 && run != 4) bad_width++;
                if (bus0.SPI_clk) rises++;
                run = 1;
            end else run++;
            prev = bus0.SPI_clk;
            if (bus0.data_valid) begin lat = n; break; end
            if (bus0.data_out !== old) bad_hold++;
        end
        chk("latency", lat, lat_exp);
        chk("data_out", bus0.data_out, exp);
        chk("cs_low_cycles", cs_low, 100);
        chk("spi_rises", rises, 12);
        chk("spi_half_period", bad_width, 0);
        chk("data_hold", bad_hold, 0);
        for (int m = 1; m <= 20; m++) begin
            @(negedge clk);
            if (bus0.data_valid) extra_dv++;
            if (!bus0.busy) begin busy_n = m; break; end
        end
        chk("busy_fall_after_cs", busy_n, 4);
        chk("dv_pulse_width", extra_dv, 0);
        if (repulse) begin
            extra_dv = 0; cs_low = 0;
            repeat (150) begin
                @(negedge clk);
                if (bus0.data_valid) extra_dv++;
                if (!bus0.cs) cs_low++;
            end
            chk("repulse_no_second_dv", extra_dv, 0);
            chk("repulse_no_second_cs", cs_low, 0);
        end
    endtask

    initial begin
        rst = 1'b1;
        bus0.start = 1'b0; bus1.start = 1'b0;
        bus0.MISO = 1'b0; bus1.MISO = 1'b0;
        word0 = '0; word1 = 12'h801;
        vecs[0] = '{12'hA5C, 12'hA5C, 101};
        vecs[1] = '{12'hFFF, 12'hFFF, 101};
        vecs[2] = '{12'h000, 12'h000, 101};
        vecs[3] = '{12'h3C6, 12'h3C6, 101};
        #1;
        chk("rst_cs", bus0.cs, 1);
        chk("rst_sclk", bus0.SPI_clk, 0);
        chk("rst_busy", bus0.busy, 0);
        chk("rst_dv", bus0.data_valid, 0);
        chk("rst_data", bus0.data_out, 0);
        chk("rst_cs_div1", bus1.cs, 1);
`ifdef SPI_READER_AUTO_EN
        begin
            int last = 0, cnt = 0;
            word0 = 12'h123;
            @(negedge clk); rst = 1'b0;
            for (int n = 1; n <= 500 && cnt < 4; n++) begin
                @(negedge clk);
                if (n == 50) bus0.start = 1'b1;
                if (bus0.data_valid) begin
                    chk("auto_interval", n - last, cnt == 0 ? 101 : 105);
                    chk("auto_data", bus0.data_out, 12'h123);
                    last = n; cnt++;
                end
            end
            chk("auto_count", cnt, 4);
            bus0.start = 1'b0;
        end
`else
        @(negedge clk); rst = 1'b0;
        for (int i = 0; i < 4; i++) read0(vecs[i].word, vecs[i].exp, vecs[i].lat, 1'b0);
        read0(12'h5A3, 12'h5A3, 101, 1'b1);
        // abort after the 6th rise
        begin
            int rises = 0, dv = 0, cs_low = 0;
            logic prev = 1'b0;
            word0 = 12'hB7E;
            @(negedge clk); bus0.start = 1'b1;
            @(negedge clk); bus0.start = 1'b0;
            for (int n = 0; n < 200 && rises < 6; n++) begin
                @(negedge clk);
                if (bus0.SPI_clk && !prev) rises++;
                prev = bus0.SPI_clk;
            end
            chk("abort_reached_rise6", rises, 6);
            rst = 1'b1;
            #1;
            chk("abort_cs", bus0.cs, 1);
            chk("abort_sclk", bus0.SPI_clk, 0);
            chk("abort_busy", bus0.busy, 0);
            chk("abort_data", bus0.data_out, 0);
            @(negedge clk); @(negedge clk); rst = 1'b0;
            repeat (150) begin
                @(negedge clk);
                if (bus0.data_valid) dv++;
                if (!bus0.cs) cs_low++;
            end
            chk("abort_no_dv", dv, 0);
            chk("abort_idle_cs", cs_low, 0);
        end
        read0(12'hA5C, 12'hA5C, 101, 1'b0);
        begin
            int lat = 0;
            word1 = 12'h801;
            @(negedge clk); bus1.start = 1'b1;
            @(negedge clk); bus1.start = 1'b0;
            for (int n = 1; n <= 80; n++) begin
                if (n > 1) @(negedge clk);
                if (bus1.data_valid) begin lat = n; break; end
            end
            chk("div1_latency", lat, 26);
            chk("div1_data", bus1.data_out, 12'h801);
        end
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
